// File: rtl/i2c_write_sequencer_if.sv
// Bus between the write sequencer and the I2C byte-write master.
interface i2c_write_sequencer_if;
    logic       m_start;
    logic [6:0] m_addr;
    logic [7:0] m_sub;
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_done;

    // Sequencer side: issues write requests and watches the master status.
    modport master (
        output m_start, m_addr, m_sub, m_data,
        input  m_ready, m_done
    );

    // I2C master side: accepts requests and reports idle/completion.
    modport slave (
        input  m_start, m_addr, m_sub, m_data,
        output m_ready, m_done
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Walks a (sub, data) table and issues one I2C register write per entry,
// spacing writes by an idle gap and aborting the run on a per-write timeout.
module i2c_write_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         NUM_WRITES = 4,
    parameter int         GAP_CYCLES = 16,
    parameter int         TIMEOUT    = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go_i,
    output logic [3:0]                   tbl_idx_o,
    input  logic [7:0]                   tbl_sub_i,
    input  logic [7:0]                   tbl_data_i,
    output logic                         busy_o,
    output logic                         done_all_o,
    output logic                         error_o,
    output logic [3:0]                   err_idx_o,
    i2c_write_sequencer_if.master        m_if
);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_WRITES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_ACCEPT = 3'd3;
    localparam logic [2:0] S_XFER   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]       state_q,   state_d;
    logic [3:0]       idx_q,     idx_d;
    logic             start_q,   start_d;
    logic [7:0]       sub_q,     sub_d;
    logic [7:0]       data_q,    data_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic [3:0]       err_idx_q, err_idx_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [GAP_W-1:0] gap_q,     gap_d;

    // Next-state logic for the sequencer FSM, counters and output registers.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_d   = start_q;
        sub_d     = sub_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                sub_d   = tbl_sub_i;
                data_d  = tbl_data_i;
                state_d = S_ARM;
            end
            S_ARM: begin
                // Waiting for an idle master does not count toward the timeout.
                if (m_if.m_ready) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT, S_XFER: begin
                timer_d = timer_q + TMR_ONE;
                if (m_if.m_done) begin
                    // Completion wins over timeout and covers a master fast
                    // enough to finish before it was seen leaving idle.
                    start_d = 1'b0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (timer_q == TMR_LAST) begin
                    // Flag the error on the timeout edge itself so error rises
                    // exactly TIMEOUT cycles after m_start.
                    start_d   = 1'b0;
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    busy_d    = 1'b0;
                    state_d   = S_ERR;
                end else if (state_q == S_ACCEPT && !m_if.m_ready) begin
                    start_d = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_GAP: begin
                if (m_if.m_ready) begin
                    if (gap_q == GAP_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        gap_d = gap_q + GAP_ONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                start_d   = 1'b0;
                err_d     = 1'b1;
                err_idx_d = idx_q;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            start_q   <= 1'b0;
            sub_q     <= 8'd0;
            data_q    <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= 4'd0;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            start_q   <= start_d;
            sub_q     <= sub_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
        end
    end

    assign tbl_idx_o    = idx_q;
    assign busy_o       = busy_q;
    assign done_all_o   = done_q;
    assign error_o      = err_q;
    assign err_idx_o    = err_idx_q;
    assign m_if.m_start = start_q;
    assign m_if.m_addr  = DEV_ADDR;
    assign m_if.m_sub   = sub_q;
    assign m_if.m_data  = data_q;
endmodule
